ib_cnu6_c2v_collector: RTL
==========================

// Module: ib_cnu6_c2v_collector
// PURPOSE
//  Return-path stage of the degree-6 IB check node unit. Regenerates the valid tag that the
//  f0..f3 2-LUT cascade does not carry, captures the six c2v messages when they emerge, and
//  buffers them in a small FIFO.
//  The FIFO drains towards the VNU/c2v memory writer over a valid/ready handshake and flags
//  the end of each layer.
// PARAMETERS
//  QUAN_SIZE        4    message width in bits
//  CASCADE_LATENCY  4    cycles from v2c_valid at cascade entry to c2v valid at cascade exit (>=1)
//  FIFO_DEPTH       4    entries of 6 messages each; power of two, >=2
//  ROW_NUM          102  c2v bundles per layer (>=2)
// PORTS
//  read_clk      in   1            clock, all state on rising edge
//  rst           in   1            asynchronous, active-high reset
//  flush         in   1            synchronous clear of tags, FIFO, counter, overflow
//  v2c_valid     in   1            v2c bundle entered the f0 stage this cycle
//  c2v0_in..c2v5_in in QUAN_SIZE   c2v messages from the final (f3) cascade stage
//  c2v0_out..c2v5_out out QUAN_SIZE FIFO head messages
//  c2v_valid     out  1            FIFO not empty
//  c2v_ready     in   1            downstream accepts head this cycle
//  fill_level    out  clog2(FIFO_DEPTH)+1  current occupancy
//  overflow      out  1            sticky: a tagged bundle was dropped
//  layer_done    out  1            one-cycle pulse, the ROW_NUM-th pop of a layer happened last cycle
// BEHAVIOUR
//  - Reset (async, rst=1): tag shift register=0, wr/rd pointers=0, fill_level=0, c2v_valid=0,
//    overflow=0, layer_done=0, row counter=0, c2v*_out=0 (storage array cleared).
//  - Tag line: CASCADE_LATENCY-deep shift register fed by v2c_valid. wr_en = its last stage, so
//    v2c_valid at cycle t captures c2v*_in at the rising edge ending cycle t+CASCADE_LATENCY.
//  - FIFO: register array, pointers with one extra wrap bit. empty = (wr==rd);
//    full = MSBs differ and the other bits are equal. Pointers wrap modulo FIFO_DEPTH.
//  - Pop: pop = c2v_valid & c2v_ready. Heads c2v*_out read combinationally from array[rd];
//    0-cycle read, a push into an empty FIFO is visible the next cycle.
//  - Push: push = wr_en & (!full | pop). Push while full with a pop in the same cycle is accepted,
//    and occupancy is unchanged. wr_en & full & !pop -> bundle dropped, overflow<=1 (sticky until
//    rst/flush).
//  - Simultaneous push+pop when not full/empty: both happen, fill_level unchanged.
//  - c2v_ready while empty is ignored. c2v*_out must hold stable while c2v_valid=1 & !c2v_ready.
//  - Row counter: increments on pop. On a pop with count==ROW_NUM-1: counter<=0 and
//    layer_done<=1 for exactly one cycle. Otherwise layer_done<=0.
//  - flush=1: tag register, pointers, counter, overflow and layer_done are cleared next edge.
//    Flush has priority over push/pop in the same cycle. In-flight tags are discarded, so
//    bundles issued before the flush are never captured.
//  - rst asserted mid-transfer: immediate clear as above. No partial bundle may remain.
// STRUCTURE
//  - Shared package/define header: QUAN_SIZE default, CNU degree constant (6), and a
//    clog2 function.
//  - One natural sub-module, ib_c2v_sync_fifo: parameterised width/depth, push/pop/full/empty/level.
//    Top level holds the tag line, overflow logic and row counter.
// TESTING
//  1 Latency: CASCADE_LATENCY=4; v2c_valid at cycle 10, c2v0_in=4'h5 only at cycle 14
//    -> c2v_valid=1 at 15 with c2v0_out=5. Values at cycles 13 and 15 are never captured.
//  2 Back-to-back: 4 consecutive v2c_valid, c2v_ready=0 -> fill_level 1,2,3,4, overflow=0.
//    A 5th tag -> overflow=1, fill_level stays 4, head unchanged.
//  3 Full with simultaneous pop: FIFO full, push and c2v_ready=1 together -> fill_level stays 4,
//    order preserved, overflow=0.
//  4 Layer end: ROW_NUM=3, pop 3 bundles -> layer_done pulses once, the cycle after the 3rd pop.
//    The 4th pop does not pulse.
//  5 Flush: 2 entries queued, 2 tags in flight, flush=1 -> fill_level=0, c2v_valid=0, and no
//    captures for the in-flight tags.
//  6 Async reset mid-stream: rst pulse between edges -> all outputs 0 immediately.
//    Traffic resumes correctly after release.

Source files
------------

// File: rtl/ib_cnu6_c2v_collector_pkg.sv
// Shared constants and helpers for the degree-6 IB check node return path.
package ib_cnu6_c2v_collector_pkg;

    localparam int unsigned CNU_DEGREE          = 6;
    localparam int unsigned QUAN_SIZE_DEF       = 4;
    localparam int unsigned CASCADE_LATENCY_DEF = 4;
    localparam int unsigned FIFO_DEPTH_DEF      = 4;
    localparam int unsigned ROW_NUM_DEF         = 102;

    // Ceiling log2; clog2(1) is 0, used for pointer and counter widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ib_c2v_sync_fifo.sv
// Single-clock register FIFO with wrap-bit pointers and a combinational head read.
module ib_c2v_sync_fifo
    import ib_cnu6_c2v_collector_pkg::*;
#(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level
);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Status flags from the pointer pair; wrap bit separates full from empty.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level = wr_ptr_q - rd_ptr_q;
        rdata = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next pointers and storage; a pop frees the slot for a same-cycle push when full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d                = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // State registers; reset also clears storage so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ib_cnu6_c2v_collector.sv
// CNU6 return path: rebuilds the valid tag lost in the f0..f3 cascade, buffers
// the six c2v messages and streams them out with end-of-layer marking.
module ib_cnu6_c2v_collector
    import ib_cnu6_c2v_collector_pkg::*;
#(
    parameter  int unsigned QUAN_SIZE       = QUAN_SIZE_DEF,
    parameter  int unsigned CASCADE_LATENCY = CASCADE_LATENCY_DEF,
    parameter  int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter  int unsigned ROW_NUM         = ROW_NUM_DEF,
    localparam int unsigned LVL_W           = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 read_clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 v2c_valid,
    input  logic [QUAN_SIZE-1:0] c2v0_in,
    input  logic [QUAN_SIZE-1:0] c2v1_in,
    input  logic [QUAN_SIZE-1:0] c2v2_in,
    input  logic [QUAN_SIZE-1:0] c2v3_in,
    input  logic [QUAN_SIZE-1:0] c2v4_in,
    input  logic [QUAN_SIZE-1:0] c2v5_in,
    output logic [QUAN_SIZE-1:0] c2v0_out,
    output logic [QUAN_SIZE-1:0] c2v1_out,
    output logic [QUAN_SIZE-1:0] c2v2_out,
    output logic [QUAN_SIZE-1:0] c2v3_out,
    output logic [QUAN_SIZE-1:0] c2v4_out,
    output logic [QUAN_SIZE-1:0] c2v5_out,
    output logic                 c2v_valid,
    input  logic                 c2v_ready,
    output logic [LVL_W-1:0]     fill_level,
    output logic                 overflow,
    output logic                 layer_done
);

    localparam int unsigned BUNDLE_W = CNU_DEGREE * QUAN_SIZE;
    localparam int unsigned ROW_W    = clog2(ROW_NUM);

    logic [CASCADE_LATENCY-1:0] tag_q, tag_d;
    logic                       overflow_q, overflow_d;
    logic                       layer_done_q, layer_done_d;
    logic [ROW_W-1:0]           row_q, row_d;

    logic                       wr_en;
    logic                       pop;
    logic                       push;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [BUNDLE_W-1:0]        bundle_in;
    logic [BUNDLE_W-1:0]        bundle_out;
    logic [LVL_W-1:0]           fifo_level;

    // Handshake decode; a push while full is only taken if the head leaves this cycle.
    always_comb begin
        wr_en     = tag_q[CASCADE_LATENCY-1];
        c2v_valid = ~fifo_empty;
        pop       = c2v_valid & c2v_ready & ~flush;
        push      = wr_en & (~fifo_full | pop) & ~flush;
        bundle_in = {c2v5_in, c2v4_in, c2v3_in, c2v2_in, c2v1_in, c2v0_in};
    end

    // Tag line, sticky overflow and per-layer row counter next state.
    always_comb begin
        tag_d        = tag_q << 1;
        tag_d[0]     = v2c_valid;
        overflow_d   = overflow_q | (wr_en & fifo_full & ~pop);
        row_d        = row_q;
        layer_done_d = 1'b0;
        if (pop) begin
            if (row_q == ROW_W'(ROW_NUM - 1)) begin
                row_d        = '0;
                layer_done_d = 1'b1;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end
        if (flush) begin
            tag_d        = '0;
            overflow_d   = 1'b0;
            row_d        = '0;
            layer_done_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            tag_q        <= '0;
            overflow_q   <= 1'b0;
            layer_done_q <= 1'b0;
            row_q        <= '0;
        end else begin
            tag_q        <= tag_d;
            overflow_q   <= overflow_d;
            layer_done_q <= layer_done_d;
            row_q        <= row_d;
        end
    end

    ib_c2v_sync_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (read_clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata (bundle_in),
        .rdata (bundle_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Output unpacking of the FIFO head and status.
    always_comb begin
        c2v0_out   = bundle_out[0*QUAN_SIZE +: QUAN_SIZE];
        c2v1_out   = bundle_out[1*QUAN_SIZE +: QUAN_SIZE];
        c2v2_out   = bundle_out[2*QUAN_SIZE +: QUAN_SIZE];
        c2v3_out   = bundle_out[3*QUAN_SIZE +: QUAN_SIZE];
        c2v4_out   = bundle_out[4*QUAN_SIZE +: QUAN_SIZE];
        c2v5_out   = bundle_out[5*QUAN_SIZE +: QUAN_SIZE];
        fill_level = fifo_level;
        overflow   = overflow_q;
        layer_done = layer_done_q;
    end

endmodule
